alien_hit_tracker: RTL and testbench

- Collision and scoring stage between the alien/beam position generators and the frame draw sequencer.
- Once per frame it latches the beam position and scans the alien array one alien per cycle. On the first overlap it kills that alien, pulses `hit` (consumed by the beam block to retire the shot) and bumps the score.
- Exports per-alien alive flags, which the draw controller uses to skip dead aliens, plus a wave-clear handshake.

---
 rtl/alien_hit_tracker.sv | 146 ++++++++++++++
 tb/tb_alien_hit_tracker.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alien_hit_tracker.sv
// Per-frame beam/alien collision scan with alive flags, score and wave-clear.
// One alien is compared per cycle against the beam position latched at frame_tick.
module alien_hit_tracker #(
    parameter int NUM_ALIENS = 8,
    parameter int ALIEN_W    = 4,
    parameter int HIT_TOP    = 4,
    parameter int HIT_ROWS   = 2,
    parameter int SCORE_W    = 8,
    localparam int IDX_W     = (NUM_ALIENS > 1) ? $clog2(NUM_ALIENS) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    frame_tick,
    input  logic                    beam_active,
    input  logic [7:0]              beam_x,
    input  logic [6:0]              beam_y,
    input  logic [8*NUM_ALIENS-1:0] alien_x_flat,
    input  logic [7*NUM_ALIENS-1:0] alien_y_flat,
    input  logic                    wave_ack,
    output logic [NUM_ALIENS-1:0]   alive,
    output logic                    hit,
    output logic [IDX_W-1:0]        hit_idx,
    output logic [SCORE_W-1:0]      score,
    output logic                    wave_clear
);

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_CLEAR} state_t;

    state_t state, state_d;

    logic [IDX_W-1:0] idx;
    logic [7:0]       bx;
    logic [6:0]       by;

    logic [7:0] ax [NUM_ALIENS];
    logic [6:0] ay [NUM_ALIENS];

    logic [7:0]        cur_x;
    logic [6:0]        cur_y;
    logic [8:0]        x_lo, x_hi, bx_w;
    logic signed [8:0] y_lo, y_hi, by_s;
    logic              x_ok, y_ok, match, last;
    logic [NUM_ALIENS-1:0] kill, alive_left;

    logic start, step, do_hit, rearm;

    always_comb begin
        for (int i = 0; i < NUM_ALIENS; i++) begin
            ax[i] = alien_x_flat[i*8 +: 8];
            ay[i] = alien_y_flat[i*7 +: 7];
        end
    end

    assign cur_x = ax[idx];
    assign cur_y = ay[idx];

    // Widened compares so boxes near the screen edges never wrap around
    assign bx_w = {1'b0, bx};
    assign x_lo = {1'b0, cur_x};
    assign x_hi = x_lo + 9'(ALIEN_W - 1);
    assign by_s = $signed({2'b00, by});
    assign y_lo = $signed({2'b00, cur_y}) - $signed(9'(HIT_TOP));
    assign y_hi = y_lo + $signed(9'(HIT_ROWS - 1));

    assign x_ok = (x_lo <= bx_w) && (bx_w <= x_hi);
    assign y_ok = (y_lo <= by_s) && (by_s <= y_hi);

    assign match      = alive[idx] && x_ok && y_ok;
    assign last       = (idx == IDX_W'(NUM_ALIENS - 1));
    assign kill       = NUM_ALIENS'(1) << idx;
    assign alive_left = alive & ~kill;

    always_comb begin
        state_d = state;
        start   = 1'b0;
        step    = 1'b0;
        do_hit  = 1'b0;
        rearm   = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (frame_tick && beam_active) begin
                    start   = 1'b1;
                    state_d = S_SCAN;
                end
            end
            S_SCAN: begin
                if (match) begin
                    do_hit  = 1'b1;
                    state_d = (alive_left == '0) ? S_CLEAR : S_IDLE;
                end else if (last) begin
                    state_d = S_IDLE;
                end else begin
                    step = 1'b1;
                end
            end
            S_CLEAR: begin
                if (wave_ack) begin
                    rearm   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            idx        <= '0;
            bx         <= '0;
            by         <= '0;
            alive      <= '1;
            hit        <= 1'b0;
            hit_idx    <= '0;
            score      <= '0;
            wave_clear <= 1'b0;
        end else begin
            state <= state_d;
            hit   <= 1'b0;
            if (start) begin
                bx  <= beam_x;
                by  <= beam_y;
                idx <= '0;
            end
            if (step) begin
                idx <= idx + 1'b1;
            end
            if (do_hit) begin
                alive   <= alive_left;
                hit     <= 1'b1;
                hit_idx <= idx;
                if (score != '1) begin
                    score <= score + 1'b1;
                end
                if (alive_left == '0) begin
                    wave_clear <= 1'b1;
                end
            end
            if (rearm) begin
                alive      <= '1;
                wave_clear <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alien_hit_tracker.sv
// Directed bench for alien_hit_tracker: vector table plus multi-cycle sequences.
module tb_alien_hit_tracker;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         frame_tick;
    logic         beam_active;
    logic [7:0]   beam_x;
    logic [6:0]   beam_y;
    logic [8*N-1:0] ax_flat;
    logic [7*N-1:0] ay_flat;
    logic         wave_ack;
    logic [N-1:0] alive;
    logic         hit;
    logic [2:0]   hit_idx;
    logic [7:0]   score;
    logic         wave_clear;

    int n_vec = 0;
    int n_bad = 0;

    alien_hit_tracker dut (
        .clk          (clk),
        .reset        (reset),
        .frame_tick   (frame_tick),
        .beam_active  (beam_active),
        .beam_x       (beam_x),
        .beam_y       (beam_y),
        .alien_x_flat (ax_flat),
        .alien_y_flat (ay_flat),
        .wave_ack     (wave_ack),
        .alive        (alive),
        .hit          (hit),
        .hit_idx      (hit_idx),
        .score        (score),
        .wave_clear   (wave_clear)
    );

    always #5 clk = ~clk;

    typedef struct {
        int       bx, by;
        bit       act;
        int       i0, x0, y0;
        int       i1, x1, y1;
        bit       exp_hit;
        int       exp_idx, exp_cyc;
        logic [7:0] exp_alive;
        int       exp_score;
    } vec_t;

    vec_t tv [12];

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic park();
        for (int i = 0; i < N; i++) begin
            ax_flat[i*8 +: 8] = 8'd200;
            ay_flat[i*7 +: 7] = 7'd10;
        end
    endtask

    task automatic place(input int i, input int x, input int y);
        ax_flat[i*8 +: 8] = 8'(x);
        ay_flat[i*7 +: 7] = 7'(y);
    endtask

    task automatic place_all(input int x, input int y);
        for (int i = 0; i < N; i++) place(i, x, y);
    endtask

    // Called and returns #1 after a rising edge; observes 12 cycles after E0
    task automatic run_frame(output int nh, output int first, output logic wc);
        nh    = 0;
        first = -1;
        wc    = 1'b0;
        frame_tick = 1'b1;
        @(posedge clk);
        #1 frame_tick = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk);
            #1;
            if (hit) begin
                nh++;
                if (first < 0) begin
                    first = c;
                    wc    = wave_clear;
                end
            end
        end
    endtask

    task automatic ack();
        wave_ack = 1'b1;
        @(posedge clk);
        #1 wave_ack = 1'b0;
    endtask

    initial begin
        int nh, first, tot, exp_score;
        logic wc;

        tv[0]  = '{10, 50, 1, 0, 8, 54, 15, 0, 0, 1, 0, 1, 8'hFE, 1};
        tv[1]  = '{40, 30, 1, 2, 40, 34, 5, 40, 34, 1, 2, 3, 8'hFA, 2};
        tv[2]  = '{40, 30, 1, 2, 40, 34, 5, 40, 34, 1, 5, 6, 8'hDA, 3};
        tv[3]  = '{12, 50, 1, 1, 8, 54, 15, 0, 0, 0, 0, 0, 8'hDA, 3};
        tv[4]  = '{5, 127, 1, 3, 5, 2, 15, 0, 0, 0, 0, 0, 8'hDA, 3};
        tv[5]  = '{11, 51, 1, 1, 8, 54, 15, 0, 0, 1, 1, 2, 8'hD8, 4};
        tv[6]  = '{8, 49, 1, 3, 8, 54, 15, 0, 0, 0, 0, 0, 8'hD8, 4};
        tv[7]  = '{7, 50, 1, 3, 8, 54, 15, 0, 0, 0, 0, 0, 8'hD8, 4};
        tv[8]  = '{255, 124, 1, 7, 252, 127, 15, 0, 0, 1, 7, 8, 8'h58, 5};
        tv[9]  = '{1, 124, 1, 6, 254, 127, 15, 0, 0, 0, 0, 0, 8'h58, 5};
        tv[10] = '{10, 50, 0, 4, 8, 54, 15, 0, 0, 0, 0, 0, 8'h58, 5};
        tv[11] = '{10, 50, 1, 0, 8, 54, 15, 0, 0, 0, 0, 0, 8'h58, 5};

        reset       = 1'b1;
        frame_tick  = 1'b0;
        beam_active = 1'b0;
        beam_x      = '0;
        beam_y      = '0;
        wave_ack    = 1'b0;
        park();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        chk("rst_alive", alive, 8'hFF);
        chk("rst_hit", hit, 0);
        chk("rst_hit_idx", hit_idx, 0);
        chk("rst_score", score, 0);
        chk("rst_wave_clear", wave_clear, 0);

        for (int k = 0; k < 12; k++) begin
            park();
            if (tv[k].i0 < N) place(tv[k].i0, tv[k].x0, tv[k].y0);
            if (tv[k].i1 < N) place(tv[k].i1, tv[k].x1, tv[k].y1);
            beam_x      = 8'(tv[k].bx);
            beam_y      = 7'(tv[k].by);
            beam_active = tv[k].act;
            run_frame(nh, first, wc);
            chk($sformatf("v%0d_hits", k), nh, tv[k].exp_hit ? 1 : 0);
            if (tv[k].exp_hit) begin
                chk($sformatf("v%0d_cycle", k), first, tv[k].exp_cyc);
                chk($sformatf("v%0d_hit_idx", k), hit_idx, tv[k].exp_idx);
            end
            chk($sformatf("v%0d_alive", k), alive, tv[k].exp_alive);
            chk($sformatf("v%0d_score", k), score, tv[k].exp_score);
        end

        // Beam and frame_tick changes mid-scan must not disturb latched scan
        park();
        place(6, 100, 60);
        beam_x      = 8'd100;
        beam_y      = 7'd56;
        beam_active = 1'b1;
        frame_tick  = 1'b1;
        @(posedge clk);
        #1 frame_tick = 1'b0;
        nh    = 0;
        first = -1;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk);
            #1;
            if (c == 1) begin
                beam_x      = 8'd0;
                beam_active = 1'b0;
                frame_tick  = 1'b1;
            end else begin
                frame_tick = 1'b0;
            end
            if (hit) begin
                nh++;
                if (first < 0) first = c;
            end
        end
        chk("latch_hits", nh, 1);
        chk("latch_cycle", first, 7);
        chk("latch_hit_idx", hit_idx, 6);
        chk("latch_alive", alive, 8'h18);
        chk("latch_score", score, 6);

        // Wave clear: last kill sets wave_clear on the hit edge
        place_all(50, 40);
        beam_x      = 8'd50;
        beam_y      = 7'd36;
        beam_active = 1'b1;
        run_frame(nh, first, wc);
        chk("wave_a_cycle", first, 4);
        chk("wave_a_idx", hit_idx, 3);
        chk("wave_a_wc", wc, 0);
        run_frame(nh, first, wc);
        chk("wave_b_cycle", first, 5);
        chk("wave_b_idx", hit_idx, 4);
        chk("wave_b_wc_at_hit", wc, 1);
        chk("wave_b_alive", alive, 0);
        chk("wave_b_score", score, 8);
        run_frame(nh, first, wc);
        chk("clear_tick_hits", nh, 0);
        chk("clear_held", wave_clear, 1);
        wave_ack   = 1'b1;
        frame_tick = 1'b1;
        @(posedge clk);
        #1;
        wave_ack   = 1'b0;
        frame_tick = 1'b0;
        chk("ack_wave_clear", wave_clear, 0);
        chk("ack_alive", alive, 8'hFF);
        nh = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            if (hit) nh++;
        end
        chk("ack_no_scan", nh, 0);
        chk("ack_score_kept", score, 8);

        // Saturation: drive the score up to 255, then one more hit
        tot       = 0;
        exp_score = 8;
        for (int n = 0; n < 247; n++) begin
            run_frame(nh, first, wc);
            tot += nh;
            exp_score = (exp_score + nh > 255) ? 255 : exp_score + nh;
            if (wave_clear) ack();
        end
        chk("sat_hits", tot, 247);
        chk("sat_score_255", score, exp_score);
        run_frame(nh, first, wc);
        if (wave_clear) ack();
        chk("sat_extra_hit", nh, 1);
        chk("sat_score_held", score, 255);

        // Reset during scan at idx 3 aborts the pending hit on alien 4
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        park();
        place(4, 50, 40);
        frame_tick = 1'b1;
        @(posedge clk);
        #1 frame_tick = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        chk("midrst_alive", alive, 8'hFF);
        chk("midrst_score", score, 0);
        chk("midrst_hit", hit, 0);
        nh = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            #1;
            if (hit) nh++;
        end
        chk("midrst_no_pulse", nh, 0);
        run_frame(nh, first, wc);
        chk("post_rst_cycle", first, 5);
        chk("post_rst_idx", hit_idx, 4);
        chk("post_rst_alive", alive, 8'hEF);
        chk("post_rst_score", score, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
